// File: rtl/fetch_unit_if.sv
// Signal bundle between the fetch stage, instruction memory, decode and the EX redirect path.
// master is the fetch stage side; slave is the environment that surrounds it.
interface fetch_unit_if;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_inst;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_inst,
        output inst_valid,
        output inst,
        output inst_pc,
        input  inst_ready,
        input  redirect_valid,
        input  redirect_pc
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_inst,
        input  inst_valid,
        input  inst,
        input  inst_pc,
        output inst_ready,
        output redirect_valid,
        output redirect_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order word reads and buffers
// returned instructions with their PC in a first-word-fall-through FIFO for decode.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int OW = CW + 1;
    localparam logic [OW-1:0] DEPTH_W = OW'(DEPTH);

    logic          run_reg;
    logic [31:0]   pc_reg;
    logic [CW-1:0] outstanding_reg;
    logic [CW-1:0] drop_cnt_reg;
    logic [CW-1:0] count_reg;
    logic [AW-1:0] pcq_wr_reg;
    logic [AW-1:0] pcq_rd_reg;
    logic [AW-1:0] fifo_wr_reg;
    logic [AW-1:0] fifo_rd_reg;

    logic [31:0] pcq_mem       [DEPTH];
    logic [31:0] fifo_pc_mem   [DEPTH];
    logic [31:0] fifo_inst_mem [DEPTH];

    logic          inst_valid_int;
    logic          pop;
    logic          req_valid;
    logic          accept;
    logic          resp;
    logic          fifo_push;
    logic          fifo_pop;
    logic [OW-1:0] occupancy;
    logic          unused_redirect_lsbs;

    // Occupancy counts in-flight requests plus buffered entries, so a full
    // FIFO can never be overrun by responses already on their way.
    assign inst_valid_int = !reset && (count_reg != '0);
    assign pop            = inst_valid_int && bus.inst_ready;
    assign occupancy      = {1'b0, outstanding_reg} + {1'b0, count_reg} - OW'(pop);
    assign req_valid      = !reset && run_reg && !bus.redirect_valid && (occupancy < DEPTH_W);
    assign accept         = req_valid && bus.imem_req_ready;
    assign resp           = bus.imem_resp_valid;
    assign fifo_push      = resp && (drop_cnt_reg == '0) && !bus.redirect_valid;
    assign fifo_pop       = pop && !bus.redirect_valid;

    assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = pc_reg;
    assign bus.inst_valid     = inst_valid_int;
    assign bus.inst           = fifo_inst_mem[fifo_rd_reg];
    assign bus.inst_pc        = fifo_pc_mem[fifo_rd_reg];

    always_ff @(posedge clk) begin
        if (reset) begin
            run_reg         <= 1'b0;
            pc_reg          <= RESET_PC;
            outstanding_reg <= '0;
            drop_cnt_reg    <= '0;
            count_reg       <= '0;
            pcq_wr_reg      <= '0;
            pcq_rd_reg      <= '0;
            fifo_wr_reg     <= '0;
            fifo_rd_reg     <= '0;
        end else begin
            run_reg <= 1'b1;

            if (bus.redirect_valid) begin
                pc_reg <= {bus.redirect_pc[31:2], 2'b00};
            end else if (accept) begin
                pc_reg <= pc_reg + 32'd4;
            end

            outstanding_reg <= outstanding_reg + CW'(accept) - CW'(resp);
            if (accept) begin
                pcq_wr_reg <= pcq_wr_reg + AW'(1);
            end
            if (resp) begin
                pcq_rd_reg <= pcq_rd_reg + AW'(1);
            end

            // Every request still in flight predates the redirect (including ones
            // already marked for dropping), so exactly those are discarded.
            if (bus.redirect_valid) begin
                drop_cnt_reg <= outstanding_reg - CW'(resp);
            end else if (resp && (drop_cnt_reg != '0)) begin
                drop_cnt_reg <= drop_cnt_reg - CW'(1);
            end

            if (bus.redirect_valid) begin
                count_reg   <= '0;
                fifo_wr_reg <= '0;
                fifo_rd_reg <= '0;
            end else begin
                if (fifo_push) begin
                    fifo_wr_reg <= fifo_wr_reg + AW'(1);
                end
                if (fifo_pop) begin
                    fifo_rd_reg <= fifo_rd_reg + AW'(1);
                end
                count_reg <= count_reg + CW'(fifo_push) - CW'(fifo_pop);
            end
        end
    end

    // Storage arrays carry no reset; validity is tracked by the pointers and counters.
    always_ff @(posedge clk) begin
        if (accept) begin
            pcq_mem[pcq_wr_reg] <= pc_reg;
        end
        if (fifo_push) begin
            fifo_pc_mem[fifo_wr_reg]   <= pcq_mem[pcq_rd_reg];
            fifo_inst_mem[fifo_wr_reg] <= bus.imem_resp_inst;
        end
        if (!reset && resp) begin
            assert (outstanding_reg != '0);
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: in-order memory model with programmable latency,
// scoreboard of expected {pc, inst} pairs checked by an independent monitor.
module tb_fetch_unit;
    logic clk   = 1'b0;
    logic reset = 1'b1;

    fetch_unit_if bus();

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #10 clk = ~clk;

    typedef struct packed { logic [31:0] pc; logic [31:0] inst; } exp_t;
    typedef struct packed { logic [31:0] addr; int due; } req_t;

    exp_t sb[$];
    req_t pend[$];

    int checks        = 0;
    int failures      = 0;
    int pop_cnt       = 0;
    int ncyc          = 0;
    int mcyc          = 0;
    int accepts       = 0;
    int lat           = 1;
    int first_pop_cyc = -1;
    int last_pop_cyc  = -1;
    bit arm_first     = 1'b0;
    bit toggle_ready  = 1'b0;
    logic [31:0] exp_addr = 32'h0;

    // Memory image: word i holds 0x1000_0000 + i.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h1000_0000 + (a >> 2);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_stream(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) begin
            sb.push_back('{pc: start + 32'(4 * i), inst: mem_word(start + 32'(4 * i))});
        end
    endtask

    // Memory model: drives at negedge+1, samples request acceptance at negedge+3.
    initial begin : mem_model
        bit          held;
        logic [31:0] held_addr;
        held = 1'b0;
        held_addr = 32'h0;
        forever begin
            @(negedge clk);
            #1;
            if (reset) begin
                pend.delete();
                bus.imem_resp_valid = 1'b0;
                bus.imem_resp_inst  = 32'hDEAD_BEEF;
                exp_addr = 32'h0;
            end else if (pend.size() != 0 && pend[0].due <= mcyc) begin
                bus.imem_resp_valid = 1'b1;
                bus.imem_resp_inst  = mem_word(pend[0].addr);
                void'(pend.pop_front());
            end else begin
                bus.imem_resp_valid = 1'b0;
                bus.imem_resp_inst  = 32'hDEAD_BEEF;
            end
            bus.imem_req_ready = toggle_ready ? mcyc[0] : 1'b1;
            #2;
            if (bus.imem_req_valid) begin
                if (held) chk("addr_hold", bus.imem_req_addr, held_addr);
                if (bus.imem_req_ready) begin
                    chk("addr_seq", bus.imem_req_addr, exp_addr);
                    exp_addr = bus.imem_req_addr + 32'd4;
                    pend.push_back('{addr: bus.imem_req_addr, due: mcyc + lat});
                    accepts++;
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    held_addr = bus.imem_req_addr;
                end
            end else begin
                held = 1'b0;
            end
            mcyc++;
        end
    end

    // Monitor: samples at negedge+4 and compares every delivered instruction.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (bus.inst_valid && bus.inst_ready && !bus.redirect_valid) begin
                pop_cnt++;
                last_pop_cyc = ncyc;
                if (arm_first) begin
                    first_pop_cyc = ncyc;
                    arm_first = 1'b0;
                end
                $display("deliver pc=%h inst=%h cycle=%0d", bus.inst_pc, bus.inst, ncyc);
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_inst: got pc=%h required no delivery", bus.inst_pc);
                end else begin
                    e = sb.pop_front();
                    chk("inst_pc", bus.inst_pc, e.pc);
                    chk("inst", bus.inst, e.inst);
                end
            end
            ncyc++;
        end
    end

    task automatic do_reset(input int nstream);
        reset = 1'b1;
        sb.delete();
        push_stream(32'h0, nstream);
        @(negedge clk);
        #2;
        chk("rst_req_valid", 32'(bus.imem_req_valid), 32'h0);
        chk("rst_inst_valid", 32'(bus.inst_valid), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        #2;
        chk("post_rst_req_valid", 32'(bus.imem_req_valid), 32'h0);
        chk("post_rst_inst_valid", 32'(bus.inst_valid), 32'h0);
        chk("post_rst_outstanding", 32'(dut.outstanding_reg), 32'h0);
    endtask

    // Called at negedge+2; holds the redirect for exactly one cycle.
    task automatic do_redirect(input logic [31:0] rpc, input logic [31:0] target, input int nstream);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = rpc;
        sb.delete();
        push_stream(target, nstream);
        exp_addr = target;
        $display("redirect to %h", rpc);
        @(negedge clk);
        bus.redirect_valid = 1'b0;
    endtask

    task automatic wait_pops(input int n, input int budget, input string name);
        int target;
        bit ok;
        target = pop_cnt + n;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #5;
            if (pop_cnt >= target) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0d deliveries required %0d", name, pop_cnt - (target - n), n);
        end
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int base;
        int a0;
        bit found;

        bus.imem_req_ready  = 1'b1;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_inst  = 32'h0;
        bus.inst_ready      = 1'b1;
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = 32'h0;

        // Throughput from reset with 1-cycle memory.
        do_reset(32);
        base = ncyc;
        arm_first = 1'b1;
        wait_pops(20, 60, "p1_stream");
        chk("p1_first_valid_cycle", 32'(first_pop_cyc - base), 32'd3);
        chk("p1_no_gaps", 32'(last_pop_cyc - first_pop_cyc), 32'd19);

        // Decode stalled: exactly DEPTH fetched, then requests stop.
        @(negedge clk);
        bus.inst_ready = 1'b0;
        do_reset(12);
        a0 = accepts;
        repeat (10) @(negedge clk);
        #2;
        chk("p2_buffered", 32'(accepts - a0), 32'd4);
        chk("p2_req_blocked", 32'(bus.imem_req_valid), 32'h0);
        chk("p2_inst_valid", 32'(bus.inst_valid), 32'h1);
        @(negedge clk);
        bus.inst_ready = 1'b1;
        wait_pops(12, 60, "p2_drain");

        // Memory back-pressure alternating every cycle.
        @(negedge clk);
        #2;
        do_redirect(32'h100, 32'h100, 32);
        toggle_ready = 1'b1;
        wait_pops(16, 120, "p3_toggle");

        // Latency 3; redirect while 3 requests are outstanding.
        @(negedge clk);
        toggle_ready = 1'b0;
        lat = 3;
        #2;
        do_redirect(32'h300, 32'h300, 0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            #2;
            if (pend.size() + int'(bus.imem_resp_valid) == 3) begin
                do_redirect(32'h203, 32'h200, 32);
                found = 1'b1;
            end
        end
        chk("p4_three_outstanding", 32'(found), 32'h1);
        wait_pops(8, 80, "p4_after_redirect");

        // Redirect in the same cycle as a response and a pop.
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            #2;
            if (bus.imem_resp_valid && bus.inst_valid && bus.inst_ready) begin
                do_redirect(32'h400, 32'h400, 32);
                found = 1'b1;
            end
        end
        chk("p5_collision", 32'(found), 32'h1);
        wait_pops(8, 80, "p5_after_redirect");

        // Reset mid-stream with 2 requests outstanding.
        @(negedge clk);
        bus.inst_ready = 1'b0;
        repeat (12) @(negedge clk);
        bus.inst_ready = 1'b1;
        #2;
        do_redirect(32'h500, 32'h500, 0);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            #2;
            if (pend.size() + int'(bus.imem_resp_valid) == 2) begin
                found = 1'b1;
                do_reset(32);
            end
        end
        chk("p6_two_outstanding", 32'(found), 32'h1);
        wait_pops(8, 80, "p6_restart");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
